i2c_wb_cmd_seq: RTL and testbench
=================================

I2C_WB_CMD_SEQ -- requirements
Module: i2c_wb_cmd_seq

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter I2C_ADDR_WIDTH, default 7, I2C slave address width.
REQ-004 SHALL have parameter NUM_I2C_BUSSES, default 1, number of buses selectable on the controller.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum clk_i cycles to wait for irq_i per byte-level command.
REQ-006 SHALL have port clk_i  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports req_valid in 1, req_ready out 1: request handshake.
REQ-009 SHALL have ports req_rw in 1 (1=read), req_addr in I2C_ADDR_WIDTH, req_data in 8, req_bus in $clog2(NUM_I2C_BUSSES)+1: request payload.
REQ-010 SHALL have ports rsp_valid out 1, rsp_data out 8, rsp_status out 2: one-cycle response pulse.
REQ-011 SHALL have Wishbone master ports cyc_o, stb_o, we_o out 1; adr_o out WB_ADDR_WIDTH; dat_o out WB_DATA_WIDTH; dat_i in WB_DATA_WIDTH; ack_i in 1; irq_i in 1.

Function
REQ-012 SHALL drive the I2C multi-bus controller register map: CSR=0, DPR=1, CMDR=2; commands Write=1, ReadNak=3, Start=4, Stop=5, SetBus=6.
REQ-013 SHALL perform each Wishbone access as: cyc_o/stb_o/we_o/adr_o/dat_o asserted and held stable until ack_i sampled high; all deasserted the following cycle; at least one idle cycle between accesses.
REQ-014 SHALL, on a read access, capture dat_i in the cycle ack_i is sampled high.
REQ-015 SHALL assert req_ready only in state IDLE; a request is accepted on the cycle req_valid && req_ready.
REQ-016 SHALL, on the first accepted request after reset or after a timeout, first write CSR=0xC0 (enable, interrupt enable); later requests skip this step.
REQ-017 SHALL sequence states IDLE -> EN -> BUS_DPR(req_bus) -> BUS_CMD(6) -> WAIT -> START(4) -> WAIT -> ADR_DPR({req_addr,req_rw}) -> ADR_CMD(1) -> WAIT -> DATA -> WAIT -> [RD_DPR] -> STOP(5) -> WAIT -> RESP -> IDLE.
REQ-018 SHALL, in DATA, write DPR=req_data then CMDR=1 for writes, and CMDR=3 for reads; RD_DPR (reads only) reads DPR into rsp_data.
REQ-019 SHALL, in WAIT, hold the bus idle until irq_i is high, then read CMDR (clearing irq) and decode status bits DON=7, NAK=6, AL=5, ERR=4.
REQ-020 SHALL map status: DON only -> continue, rsp_status=0 (OK); NAK -> jump to STOP, rsp_status=1; AL -> jump to RESP without STOP, rsp_status=2; ERR -> jump to STOP, rsp_status=3.
REQ-021 SHALL, if the first-priority status is from the STOP wait, keep any earlier non-OK status.
REQ-022 SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES: rsp_status=3, clear the enabled flag, go to RESP.
REQ-023 SHALL drive rsp_data=0x00 for writes and for any failed read.
REQ-024 SHALL pulse rsp_valid for exactly one cycle in RESP, with rsp_data and rsp_status stable in that cycle; no backpressure.
REQ-025 SHALL ignore req_valid and all payload changes while not in IDLE; payload latched at acceptance.
REQ-026 SHALL treat irq_i asserted outside WAIT as don't-care.

Reset
REQ-027 SHALL, while rst_i is low, force state IDLE, enabled flag 0, counter 0, and all outputs 0 except req_ready.
REQ-028 SHALL drive req_ready=1 immediately on reset assertion (IDLE).
REQ-029 SHALL, on reset mid-access, drop cyc_o/stb_o asynchronously and issue no response.

Verification
REQ-030 Write bus0 addr 0x22 data 0x5A after reset, OK irqs -> WB writes CSR C0, DPR 00, CMDR 06, CMDR 04, DPR 44, CMDR 01, DPR 5A, CMDR 01, CMDR 05; rsp_status=0, rsp_data=00.
REQ-031 Read addr 0x22, slave returns 0xA7 -> DPR 45, CMDR 03, DPR read; rsp_data=A7, status=0; no CSR write on second request.
REQ-032 Address NAK (CMDR read 0xC0 after ADR_CMD) -> no DATA writes, STOP issued, rsp_status=1.
REQ-033 Arbitration lost (CMDR read 0xA0 after START) -> no STOP, rsp_status=2, next request re-runs SetBus.
REQ-034 irq_i held low, TIMEOUT_CYCLES=16 -> rsp_status=3 after 16 WAIT cycles; next request begins with CSR write C0.
REQ-035 ack_i delayed 3 cycles on every access, plus rst_i pulsed low mid-DATA -> signals held stable until ack; after reset cyc_o=0, req_ready=1, no rsp_valid.

Source files
------------

// File: rtl/i2c_wb_cmd_seq.sv
// ---------------------------------------------------------------------------
// i2c_wb_cmd_seq
//
// Turns one byte-level I2C request (single write or single read of one byte)
// into the Wishbone register sequence understood by an I2C multi-bus
// controller (CSR=0, DPR=1, CMDR=2). The controller is enabled once (CSR=0xC0)
// and re-enabled after a timeout. Each controller command is followed by a
// wait for irq_i, a CMDR read that clears the interrupt and a status decode.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_rw/addr/data/bus    request payload (req_rw=1 is a read)
//   rsp_valid/data/status   one-cycle response pulse (0 OK, 1 NAK, 2 AL, 3 ERR)
//   cyc_o..dat_o, dat_i,    Wishbone master towards the controller
//   ack_i, irq_i
//   dbg_state               current sequencer state, for checkers
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only while idle; the payload is
// captured on that edge and later payload changes are ignored. rsp_valid is a
// single-cycle pulse that cannot be back-pressured.
// ---------------------------------------------------------------------------
module i2c_wb_cmd_seq #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int NUM_I2C_BUSSES = 1,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int BUS_W = $clog2(NUM_I2C_BUSSES) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rw,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]                req_data,
    input  logic [BUS_W-1:0]          req_bus,
    output logic                      rsp_valid,
    output logic [7:0]                rsp_data,
    output logic [1:0]                rsp_status,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i,
    output logic [3:0]                dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

    localparam logic [WB_DATA_WIDTH-1:0] CSR_EN      = WB_DATA_WIDTH'(8'hC0);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_WRITE   = WB_DATA_WIDTH'(8'd1);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_READNAK = WB_DATA_WIDTH'(8'd3);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_START   = WB_DATA_WIDTH'(8'd4);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_STOP    = WB_DATA_WIDTH'(8'd5);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_SETBUS  = WB_DATA_WIDTH'(8'd6);

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_NAK = 2'd1;
    localparam logic [1:0] ST_AL  = 2'd2;
    localparam logic [1:0] ST_ERR = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_EN, S_BUS_DPR, S_BUS_CMD, S_WAIT, S_START, S_ADR_DPR,
        S_ADR_CMD, S_DATA_DPR, S_DATA_CMD, S_RD_DPR, S_STOP, S_RESP
    } state_t;

    // Which command the WAIT state is waiting on; selects where to resume.
    typedef enum logic [2:0] {P_BUS, P_START, P_ADR, P_DATA, P_STOP} phase_t;

    state_t state, state_d;
    phase_t phase, phase_d;

    logic                      enabled;
    logic [CNT_W-1:0]          wait_cnt;
    logic                      lat_rw;
    logic [I2C_ADDR_WIDTH-1:0] lat_addr;
    logic [7:0]                lat_data;
    logic [BUS_W-1:0]          lat_bus;
    logic [7:0]                rd_data;
    logic [1:0]                status_r, status_d;

    logic                      done;
    logic                      launch;
    logic                      acc_we;
    logic [WB_ADDR_WIDTH-1:0]  acc_adr;
    logic [WB_DATA_WIDTH-1:0]  acc_dat;
    logic                      accept, set_en, clr_en, cnt_inc, cnt_clr, cap_rd;
    logic [1:0]                irq_code;

    assign done = cyc_o && ack_i;

    // CMDR status decode. Arbitration loss wins because no STOP may follow it;
    // an interrupt with DON clear and no error flag is treated as an error.
    always_comb begin
        irq_code = ST_ERR;
        if (dat_i[5])      irq_code = ST_AL;
        else if (dat_i[4]) irq_code = ST_ERR;
        else if (dat_i[6]) irq_code = ST_NAK;
        else if (dat_i[7]) irq_code = ST_OK;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            phase <= P_BUS;
        end else begin
            state <= state_d;
            phase <= phase_d;
        end
    end

    // Every access state launches its access when the bus is idle (the first
    // cycle in a state is always idle, which gives the inter-access gap) and
    // advances on the cycle ack_i is sampled.
    always_comb begin
        state_d  = state;
        phase_d  = phase;
        status_d = status_r;
        launch   = 1'b0;
        acc_we   = 1'b1;
        acc_adr  = ADR_CSR;
        acc_dat  = '0;
        accept   = 1'b0;
        set_en   = 1'b0;
        clr_en   = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        cap_rd   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept   = 1'b1;
                    status_d = ST_OK;
                    state_d  = enabled ? S_BUS_DPR : S_EN;
                end
            end
            S_EN: begin
                acc_adr = ADR_CSR;
                acc_dat = CSR_EN;
                launch  = !cyc_o;
                if (done) begin
                    set_en  = 1'b1;
                    state_d = S_BUS_DPR;
                end
            end
            S_BUS_DPR: begin
                acc_adr = ADR_DPR;
                acc_dat = WB_DATA_WIDTH'(lat_bus);
                launch  = !cyc_o;
                if (done) state_d = S_BUS_CMD;
            end
            S_BUS_CMD: begin
                acc_adr = ADR_CMDR;
                acc_dat = CMD_SETBUS;
                launch  = !cyc_o;
                if (done) begin
                    phase_d = P_BUS;
                    state_d = S_WAIT;
                end
            end
            S_START: begin
                acc_adr = ADR_CMDR;
                acc_dat = CMD_START;
                launch  = !cyc_o;
                if (done) begin
                    phase_d = P_START;
                    state_d = S_WAIT;
                end
            end
            S_ADR_DPR: begin
                acc_adr = ADR_DPR;
                acc_dat = WB_DATA_WIDTH'({lat_addr, lat_rw});
                launch  = !cyc_o;
                if (done) state_d = S_ADR_CMD;
            end
            S_ADR_CMD: begin
                acc_adr = ADR_CMDR;
                acc_dat = CMD_WRITE;
                launch  = !cyc_o;
                if (done) begin
                    phase_d = P_ADR;
                    state_d = S_WAIT;
                end
            end
            S_DATA_DPR: begin
                acc_adr = ADR_DPR;
                acc_dat = WB_DATA_WIDTH'(lat_data);
                launch  = !cyc_o;
                if (done) state_d = S_DATA_CMD;
            end
            S_DATA_CMD: begin
                acc_adr = ADR_CMDR;
                acc_dat = lat_rw ? CMD_READNAK : CMD_WRITE;
                launch  = !cyc_o;
                if (done) begin
                    phase_d = P_DATA;
                    state_d = S_WAIT;
                end
            end
            S_RD_DPR: begin
                acc_we  = 1'b0;
                acc_adr = ADR_DPR;
                launch  = !cyc_o;
                if (done) begin
                    cap_rd  = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                acc_adr = ADR_CMDR;
                acc_dat = CMD_STOP;
                launch  = !cyc_o;
                if (done) begin
                    phase_d = P_STOP;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                acc_we  = 1'b0;
                acc_adr = ADR_CMDR;
                if (!cyc_o) begin
                    if (irq_i) begin
                        launch  = 1'b1;
                        cnt_clr = 1'b1;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Controller is unresponsive: force re-enable next time.
                        cnt_clr  = 1'b1;
                        clr_en   = 1'b1;
                        status_d = ST_ERR;
                        state_d  = S_RESP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (ack_i) begin
                    if (phase == P_STOP) begin
                        // A failure reported by STOP must not hide an earlier one.
                        state_d = S_RESP;
                        if (status_r == ST_OK) status_d = irq_code;
                    end else if (irq_code == ST_OK) begin
                        case (phase)
                            P_BUS:   state_d = S_START;
                            P_START: state_d = S_ADR_DPR;
                            P_ADR:   state_d = lat_rw ? S_DATA_CMD : S_DATA_DPR;
                            P_DATA:  state_d = lat_rw ? S_RD_DPR : S_STOP;
                            default: state_d = S_STOP;
                        endcase
                    end else if (irq_code == ST_AL) begin
                        status_d = ST_AL;
                        state_d  = S_RESP;
                    end else begin
                        status_d = irq_code;
                        state_d  = S_STOP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            enabled  <= 1'b0;
            wait_cnt <= '0;
            lat_rw   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_bus  <= '0;
            rd_data  <= '0;
            status_r <= ST_OK;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            we_o     <= 1'b0;
            adr_o    <= '0;
            dat_o    <= '0;
        end else begin
            status_r <= status_d;
            if (accept) begin
                lat_rw   <= req_rw;
                lat_addr <= req_addr;
                lat_data <= req_data;
                lat_bus  <= req_bus;
            end
            if (set_en)      enabled <= 1'b1;
            else if (clr_en) enabled <= 1'b0;
            if (cnt_clr)      wait_cnt <= '0;
            else if (cnt_inc) wait_cnt <= wait_cnt + CNT_W'(1);
            if (accept)      rd_data <= 8'h00;
            else if (cap_rd) rd_data <= dat_i[7:0];
            if (launch) begin
                cyc_o <= 1'b1;
                stb_o <= 1'b1;
                we_o  <= acc_we;
                adr_o <= acc_adr;
                dat_o <= acc_dat;
            end else if (done) begin
                cyc_o <= 1'b0;
                stb_o <= 1'b0;
                we_o  <= 1'b0;
                adr_o <= '0;
                dat_o <= '0;
            end
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign rsp_valid  = (state == S_RESP);
    assign rsp_status = rsp_valid ? status_r : ST_OK;
    assign rsp_data   = (rsp_valid && lat_rw && status_r == ST_OK) ? rd_data : 8'h00;
    assign dbg_state  = state;

endmodule

// File: tb/tb_i2c_wb_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_wb_cmd_seq
//
// Directed bench for i2c_wb_cmd_seq. A behavioural controller model answers
// Wishbone accesses and raises irq_i after each command; a transaction-level
// model predicts the ordered list of register accesses and the response of
// each request, and a negedge monitor checks the DUT against it every cycle.
// ---------------------------------------------------------------------------
module tb_i2c_wb_cmd_seq;

    localparam int TO = 16;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic [0:0] req_bus = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_status;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack_i;
    logic       irq_i;
    logic [3:0] dbg_state;

    i2c_wb_cmd_seq #(
        .WB_ADDR_WIDTH (2),
        .WB_DATA_WIDTH (8),
        .I2C_ADDR_WIDTH(7),
        .NUM_I2C_BUSSES(1),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_bus   (req_bus),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_status(rsp_status),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .dat_i     (dat_i),
        .ack_i     (ack_i),
        .irq_i     (irq_i),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] exp_q[$];      // {we, adr, write data or 0 for reads}
    logic [9:0]  exp_rsp_q[$];  // {status, data}
    int          scr[$];        // per-wait status byte, -1 = irq never comes
    int          sl_q[$];       // controller model's copy of the script
    logic [7:0]  sl_rd = 8'h00; // byte the controller returns from DPR
    int          ack_dly = 0;
    bit          m_en = 1'b0;   // model's view of "controller enabled"

    logic [9:0]  last_rsp = '0;
    int          last_idle = 0;
    int          rsp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event expected none at %0t", name, $time);
    endtask

    function automatic logic [10:0] acc(input logic we, input logic [1:0] adr, input logic [7:0] d);
        return {we, adr, (we ? d : 8'h00)};
    endfunction

    // CMDR byte -> response code (bit7 DON, bit6 NAK, bit5 AL, bit4 ERR)
    function automatic logic [1:0] dec(input int s);
        logic [7:0] b;
        b = s[7:0];
        if (b[5]) return 2'd2;
        if (b[4]) return 2'd3;
        if (b[6]) return 2'd1;
        if (b[7]) return 2'd0;
        return 2'd3;
    endfunction

    // Transaction model: the command phases are SetBus, Start, Address, Data,
    // each followed by a CMDR read; then optional DPR read, Stop and its read.
    function automatic void model_txn(input bit rw, input logic [6:0] a, input logic [7:0] d,
                                      input logic [7:0] bus, input logic [7:0] rb);
        int k;
        logic [1:0] st;
        bit tout;
        k = 0;
        st = 2'd0;
        tout = 1'b0;
        if (!m_en) begin
            exp_q.push_back(acc(1'b1, 2'd0, 8'hC0));
            m_en = 1'b1;
        end
        for (int p = 0; p < 4 && st == 2'd0 && !tout; p++) begin
            case (p)
                0: begin
                    exp_q.push_back(acc(1'b1, 2'd1, bus));
                    exp_q.push_back(acc(1'b1, 2'd2, 8'd6));
                end
                1: exp_q.push_back(acc(1'b1, 2'd2, 8'd4));
                2: begin
                    exp_q.push_back(acc(1'b1, 2'd1, {a, rw}));
                    exp_q.push_back(acc(1'b1, 2'd2, 8'd1));
                end
                default: begin
                    if (rw) exp_q.push_back(acc(1'b1, 2'd2, 8'd3));
                    else begin
                        exp_q.push_back(acc(1'b1, 2'd1, d));
                        exp_q.push_back(acc(1'b1, 2'd2, 8'd1));
                    end
                end
            endcase
            if (scr[k] < 0) tout = 1'b1;
            else begin
                exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
                st = dec(scr[k]);
            end
            k++;
        end
        if (tout) begin
            st = 2'd3;
            m_en = 1'b0;
        end else if (st != 2'd2) begin
            if (st == 2'd0 && rw) exp_q.push_back(acc(1'b0, 2'd1, 8'h00));
            exp_q.push_back(acc(1'b1, 2'd2, 8'd5));
            if (scr[k] < 0) begin
                st = 2'd3;
                m_en = 1'b0;
            end else begin
                exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
                if (st == 2'd0) st = dec(scr[k]);
            end
        end
        exp_rsp_q.push_back({st, ((rw && st == 2'd0) ? rb : 8'h00)});
    endfunction

    // ---------------- controller model (Wishbone slave) ----------------
    initial begin : wb_slave
        int dly_cnt;
        int irq_cnt;
        dly_cnt = 0;
        irq_cnt = 0;
        ack_i = 1'b0;
        dat_i = 8'h00;
        irq_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_i) begin
                ack_i = 1'b0;
                irq_i = 1'b0;
                dly_cnt = 0;
                irq_cnt = 0;
            end else begin
                if (irq_cnt > 0) begin
                    irq_cnt--;
                    if (irq_cnt == 0) irq_i = 1'b1;
                end
                if (ack_i) ack_i = 1'b0;
                else if (cyc_o && stb_o) begin
                    if (dly_cnt < ack_dly) dly_cnt++;
                    else begin
                        dly_cnt = 0;
                        ack_i = 1'b1;
                        dat_i = 8'h00;
                        if (we_o && adr_o == 2'd2) begin
                            if (sl_q.size() > 0 && sl_q[0] < 0) void'(sl_q.pop_front());
                            else irq_cnt = 3;
                        end else if (!we_o && adr_o == 2'd2) begin
                            if (sl_q.size() > 0) dat_i = 8'(sl_q.pop_front());
                            irq_i = 1'b0;
                        end else if (!we_o && adr_o == 2'd1) begin
                            dat_i = sl_rd;
                        end
                    end
                end else begin
                    dly_cnt = 0;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic        prev_cyc = 1'b0, prev_ack = 1'b0, prev_rsp = 1'b0;
    logic [10:0] prev_sig = '0;
    int          idle_run = 0;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            prev_cyc = 1'b0;
            prev_ack = 1'b0;
            prev_rsp = 1'b0;
            idle_run = 0;
        end else begin
            if (prev_ack) chk("idle_after_ack", {cyc_o, stb_o, we_o}, 3'b000);
            if (prev_cyc && !prev_ack) begin
                chk("held_until_ack", {cyc_o, stb_o}, 2'b11);
                chk("held_stable", {we_o, adr_o, dat_o}, prev_sig);
            end
            if (cyc_o) chk("ready_low_when_busy", req_ready, 1'b0);
            if (cyc_o && ack_i) begin
                if (exp_q.size() == 0) fail_now("unexpected_access");
                else chk("wb_access", acc(we_o, adr_o, dat_o), exp_q.pop_front());
            end
            if (prev_rsp) chk("rsp_one_cycle", rsp_valid, 1'b0);
            if (rsp_valid) begin
                rsp_cnt++;
                last_rsp = {rsp_status, rsp_data};
                last_idle = idle_run;
                if (exp_rsp_q.size() == 0) fail_now("unexpected_rsp");
                else chk("rsp", {rsp_status, rsp_data}, exp_rsp_q.pop_front());
            end
            if (cyc_o) idle_run = 0;
            else idle_run++;
            prev_cyc = cyc_o;
            prev_ack = cyc_o && ack_i;
            prev_rsp = rsp_valid;
            prev_sig = {we_o, adr_o, dat_o};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic arm(input bit rw, input logic [6:0] a, input logic [7:0] d,
                       input logic bus, input logic [7:0] rb);
        sl_rd = rb;
        foreach (scr[i]) sl_q.push_back(scr[i]);
        model_txn(rw, a, d, {7'b0, bus}, rb);
    endtask

    task automatic drive(input bit rw, input logic [6:0] a, input logic [7:0] d, input logic bus);
        @(negedge clk_i);
        req_rw = rw;
        req_addr = a;
        req_data = d;
        req_bus = bus;
        req_valid = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid = 1'b0;
        // payload changes while busy must be ignored
        req_rw = 1'($urandom_range(0, 1));
        req_addr = 7'($urandom_range(0, 127));
        req_data = 8'($urandom_range(0, 255));
        req_bus = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_rsp_q.size() != 0 || !req_ready) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk("txn_finished_in_budget", exp_rsp_q.size(), 0);
        chk("all_accesses_seen", exp_q.size(), 0);
    endtask

    task automatic send(input bit rw, input logic [6:0] a, input logic [7:0] d,
                        input logic bus, input logic [7:0] rb);
        arm(rw, a, d, bus, rb);
        drive(rw, a, d, bus);
        wait_done(600);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int n;
        int snap;
        repeat (3) @(negedge clk_i);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_bus_idle", {cyc_o, stb_o, we_o, adr_o, dat_o}, '0);
        chk("reset_rsp", {rsp_valid, rsp_status, rsp_data}, '0);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // T1: first write after reset, enables the controller
        scr = '{128, 128, 128, 128, 128};
        arm(1'b0, 7'h22, 8'h5A, 1'b0, 8'h00);
        chk("model_t1_len", exp_q.size(), 14);
        chk("model_t1_csr", exp_q[0], {1'b1, 2'd0, 8'hC0});
        chk("model_t1_adr", exp_q[6], {1'b1, 2'd1, 8'h44});
        chk("model_t1_data", exp_q[9], {1'b1, 2'd1, 8'h5A});
        drive(1'b0, 7'h22, 8'h5A, 1'b0);
        wait_done(600);
        chk("t1_rsp_literal", last_rsp, {2'd0, 8'h00});

        // T2: read, no CSR write
        scr = '{128, 128, 128, 128, 128};
        arm(1'b1, 7'h22, 8'h00, 1'b0, 8'hA7);
        chk("model_t2_len", exp_q.size(), 13);
        drive(1'b1, 7'h22, 8'h00, 1'b0);
        wait_done(600);
        chk("t2_rsp_literal", last_rsp, {2'd0, 8'hA7});

        // T3: address NAK, STOP reports ERR which must not replace NAK
        scr = '{128, 128, 192, 144};
        send(1'b0, 7'h31, 8'h11, 1'b0, 8'h00);
        chk("t3_rsp_literal", last_rsp, {2'd1, 8'h00});

        // T4: arbitration lost after START, no STOP
        scr = '{128, 160};
        send(1'b1, 7'h10, 8'h00, 1'b0, 8'h99);
        chk("t4_rsp_literal", last_rsp, {2'd2, 8'h00});

        // T5: next request re-runs SetBus, on bus 1
        scr = '{128, 128, 128, 128, 128};
        arm(1'b0, 7'h22, 8'h33, 1'b1, 8'h00);
        chk("model_t5_setbus_first", exp_q[0], {1'b1, 2'd1, 8'h01});
        drive(1'b0, 7'h22, 8'h33, 1'b1);
        wait_done(600);

        // T6: ERR on data phase of a read -> STOP, data forced to 0
        scr = '{128, 128, 128, 144, 128};
        send(1'b1, 7'h55, 8'h00, 1'b0, 8'hEE);
        chk("t6_rsp_literal", last_rsp, {2'd3, 8'h00});

        // T7: everything OK until STOP reports NAK
        scr = '{128, 128, 128, 128, 192};
        send(1'b0, 7'h7F, 8'hFF, 1'b0, 8'h00);
        chk("t7_rsp_literal", last_rsp, {2'd1, 8'h00});

        // T8: irq never arrives after START -> timeout
        scr = '{128, -1};
        send(1'b0, 7'h22, 8'h01, 1'b0, 8'h00);
        chk("t8_rsp_literal", last_rsp, {2'd3, 8'h00});
        chk("t8_wait_cycles", last_idle, TO);

        // T9: after a timeout the controller is re-enabled
        scr = '{128, 128, 128, 128, 128};
        arm(1'b1, 7'h01, 8'h00, 1'b0, 8'h3C);
        chk("model_t9_csr_first", exp_q[0], {1'b1, 2'd0, 8'hC0});
        drive(1'b1, 7'h01, 8'h00, 1'b0);
        wait_done(600);
        chk("t9_rsp_literal", last_rsp, {2'd0, 8'h3C});

        // T10: slow acks, reset in the middle of the data DPR write
        ack_dly = 3;
        scr = '{128, 128, 128, 128, 128};
        arm(1'b0, 7'h22, 8'h6C, 1'b0, 8'h00);
        drive(1'b0, 7'h22, 8'h6C, 1'b0);
        n = 0;
        while (!(cyc_o && we_o && adr_o == 2'd1 && dat_o == 8'h6C) && n < 600) begin
            @(negedge clk_i);
            n++;
        end
        chk("t10_reached_data", (n < 600), 1'b1);
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("t10_rst_cyc_drop", {cyc_o, stb_o}, 2'b00);
        chk("t10_rst_ready", req_ready, 1'b1);
        chk("t10_rst_no_rsp", rsp_valid, 1'b0);
        exp_q.delete();
        exp_rsp_q.delete();
        sl_q.delete();
        m_en = 1'b0;
        snap = rsp_cnt;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (20) @(negedge clk_i);
        chk("t10_no_rsp_after_reset", rsp_cnt, snap);
        chk("t10_bus_idle_after_reset", cyc_o, 1'b0);

        // T11: full slow-ack transaction after reset, starts with CSR again
        scr = '{128, 128, 128, 128, 128};
        send(1'b1, 7'h22, 8'h00, 1'b0, 8'h5C);
        chk("t11_rsp_literal", last_rsp, {2'd0, 8'h5C});

        repeat (5) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
